// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    localparam int unsigned MDU_ITERS     = 32;
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

    function automatic logic op_is_signed(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Register-file side bus of the multiply/divide unit: operands, MTHI/MTLO and HI/LO results.
interface mul_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    import mdu_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, busA, busB, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, busA, busB, hi_we, lo_we,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add for multiply, restoring trial subtract for divide.
module mdu_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] low_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        sum     = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        shifted = {acc, low[WIDTH-1]};
        ge      = shifted >= {1'b0, opnd};
        if (is_div) begin
            // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
            acc_nxt = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
            low_nxt = {low[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            low_nxt = {sum[0], low[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mul_div_unit_if.slave  bus
);

    localparam int unsigned CntW = $clog2(MDU_ITERS);
    localparam logic [CntW-1:0] CntLast = CntW'(MDU_ITERS - 1);

    mdu_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_low;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (is_div_q),
        .acc     (acc_q),
        .low     (low_q),
        .opnd    (opnd_q),
        .acc_nxt (step_acc),
        .low_nxt (step_low)
    );

    always_comb begin
        signed_op = op_is_signed(bus.op);
        a_mag     = (signed_op && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
        b_mag     = (signed_op && bus.busB[WIDTH-1]) ? -bus.busB : bus.busB;
        prod      = {acc_q, low_q};
        prod_fix  = qsign_q ? -prod : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        qsign_d  = qsign_q;
        rsign_d  = rsign_q;
        div0_d   = div0_q;
        araw_d   = araw_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d = op_is_div(bus.op);
                    qsign_d  = signed_op & (bus.busA[WIDTH-1] ^ bus.busB[WIDTH-1]);
                    rsign_d  = signed_op & bus.busA[WIDTH-1];
                    div0_d   = op_is_div(bus.op) && (bus.busB == '0);
                    araw_d   = bus.busA;
                    acc_d    = '0;
                    // Multiply walks the multiplier (B) through low; divide walks the dividend.
                    low_d    = op_is_div(bus.op) ? a_mag : b_mag;
                    opnd_d   = op_is_div(bus.op) ? b_mag : a_mag;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    if (bus.hi_we) hi_d = bus.busA;
                    if (bus.lo_we) lo_d = bus.busA;
                end
            end
            RUN: begin
                acc_d = step_acc;
                low_d = step_low;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div0_q) begin
                    hi_d = araw_q;
                    lo_d = DIV0_QUOTIENT;
                end else begin
                    hi_d = rsign_q ? -acc_q : acc_q;
                    lo_d = qsign_q ? -low_q : low_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            div0_q   <= 1'b0;
            araw_q   <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            qsign_q  <= qsign_d;
            rsign_q  <= rsign_d;
            div0_q   <= div0_d;
            araw_q   <= araw_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases, hazards, reset abort, random ops.
module tb_mul_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.hi = '0;
        e.lo = '0;
        case (op)
            MDU_MULT: begin
                p = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            MDU_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFFFFFF;
                end else if (op == MDU_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = 32'(q);
                    e.hi = 32'(r);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Launch one op; at iteration inject_at, pulse start, hi_we and lo_we with junk operands.
    task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int inject_at);
        exp_t        e;
        int          n;
        int          busy_cnt;
        bit          got;
        bit          hold_ok;
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        @(negedge clk);
        hi_prev   = bus.hi;
        lo_prev   = bus.lo;
        bus.op    = op;
        bus.busA  = a;
        bus.busB  = b;
        bus.start = 1'b1;
        e.hi = ehi;
        e.lo = elo;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        hold_ok   = (bus.hi === hi_prev) && (bus.lo === lo_prev);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.op    = MDU_DIVU;
                bus.busA  = 32'h1234;
                bus.busB  = 32'h7;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
            end
            @(posedge clk);
            n++;
            #1;
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
            else if ((bus.hi !== hi_prev) || (bus.lo !== lo_prev)) hold_ok = 1'b0;
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            check({tag, "_hi"}, bus.hi, e.hi);
            check({tag, "_lo"}, bus.lo, e.lo);
            check({tag, "_latency"}, 32'(n), 32'd33);
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
            check({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        end
    endtask

    task automatic idle_write(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        bus.busA  = d;
        bus.hi_we = h;
        bus.lo_we = l;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mdu_op_e     rop;
        logic [31:0] ra;
        logic [31:0] rb;
        exp_t        m;
        bit          seen;

        bus.start = 1'b0;
        bus.op    = MDU_MULT;
        bus.busA  = '0;
        bus.busB  = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1);
        run_op("mult_neg3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        run_op("mult_min_sq", MDU_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, -1);
        run_op("div_m7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div_7_m2", MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, -1);
        run_op("divu_7_2", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, -1);
        run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1);
        run_op("divu_5_0", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, -1);
        run_op("div_m5_0", MDU_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, -1);

        // Start and MTHI/MTLO during RUN must be ignored.
        run_op("hazard", MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 5);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check("hazard_idle", {31'd0, bus.busy}, 32'd0);

        idle_write(1'b1, 1'b0, 32'h1234);
        check("mthi_hi", bus.hi, 32'h1234);
        check("mthi_lo_kept", bus.lo, 32'd12);
        idle_write(1'b1, 1'b1, 32'hA5A5_5A5A);
        check("mthilo_hi", bus.hi, 32'hA5A5_5A5A);
        check("mthilo_lo", bus.lo, 32'hA5A5_5A5A);

        // Start wins over a simultaneous MTLO in IDLE.
        @(negedge clk);
        bus.op    = MDU_DIVU;
        bus.busA  = 32'd100;
        bus.busB  = 32'd7;
        bus.start = 1'b1;
        bus.lo_we = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        check("start_wins_lo", bus.lo, 32'hA5A5_5A5A);
        check("start_wins_busy", {31'd0, bus.busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("start_wins_done", {31'd0, seen}, 32'd1);
        check("start_wins_q", bus.lo, 32'd14);
        check("start_wins_r", bus.hi, 32'd2);

        // Reset at RUN edge 10 aborts without a done pulse or result.
        @(negedge clk);
        bus.op    = MDU_MULTU;
        bus.busA  = 32'hFFFFFFFF;
        bus.busB  = 32'hFFFFFFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        check("abort_hi_after", bus.hi, 32'd0);
        run_op("after_rst", MDU_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, -1);

        for (int i = 0; i < 10; i++) begin
            rop = mdu_op_e'(2'($urandom_range(0, 3)));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 3 == 1) rb = ~rb + 32'd1;
            m = model(rop, ra, rb);
            run_op($sformatf("rand%0d", i), rop, ra, rb, m.hi, m.lo, -1);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
